coherence_bus_arbiter: RTL and testbench

//  Arbitrates the shared coherence bus and unified-memory port between the two per-CPU cache controllers.

---
 rtl/coherence_bus_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_coherence_bus_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/coherence_bus_arbiter.sv
// coherence_bus_arbiter
//   Arbitrates the shared coherence bus and the unified-memory port between
//   the two per-CPU cache controllers. One requester is granted at a time.
//   The arbiter drives BOCI to the peer cache and sequences the snoop. After
//   the snoop it finishes with either a peer-supplied fill or a unified-memory
//   access that is gated by cpu_dmem_permission.
//
// Ports
//   clk                  system clock, all logic on posedge
//   rst                  synchronous, active-high reset
//   req[1:0]             per-CPU level request, held until done[i]
//   req_op[3:0]          per-CPU op [2i+1:2i]: 00 rd miss, 01 wr miss, 10 inval, 11 writeback
//   req_addr             per-CPU line address [ADDR_W*i +: ADDR_W]
//   snoop_found[1:0]     cpu_search_found from each cache
//   u_rdy                unified memory access complete
//   grant[1:0]           one-hot bus grant, held from GRANT through DONE
//   cpu_search[1:0]      one-cycle snoop strobe to the non-granted cache
//   BOCI                 bus-observed line address of the current winner
//   cpu_datasel[1:0]     fill source: 00 memory, 01 peer, 11 none
//   cpu_dmem_permission  unified-memory permission, winner bit only
//   done[1:0]            one-cycle completion pulse to the winner
//   busy                 high in every state except IDLE
//
// Configuration
//   ARB_FIXED_PRIORITY_EN  defined: CPU0 always wins simultaneous requests.
//                          undefined (default): round-robin on the last grant.

module coherence_bus_arbiter #(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned SNOOP_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [3:0]            req_op,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [1:0]            snoop_found,
  input  logic                  u_rdy,
  output logic [1:0]            grant,
  output logic [1:0]            cpu_search,
  output logic [ADDR_W-1:0]     BOCI,
  output logic [1:0]            cpu_datasel,
  output logic [1:0]            cpu_dmem_permission,
  output logic [1:0]            done,
  output logic                  busy
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] OP_INV = 2'b10;
  localparam logic [1:0] OP_WB  = 2'b11;

  localparam logic [1:0] SEL_MEM  = 2'b00;
  localparam logic [1:0] SEL_PEER = 2'b01;
  localparam logic [1:0] SEL_NONE = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    SNOOP = 3'd2,
    MEM   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state, state_n;
  logic              w_q, w_n;
  logic [1:0]        op_q, op_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;

  logic [1:0]        grant_n;
  logic [1:0]        search_n;
  logic [ADDR_W-1:0] boci_n;
  logic [1:0]        datasel_n;
  logic [1:0]        perm_n;
  logic [1:0]        done_n;
  logic              busy_n;

  logic              win_c;

`ifdef ARB_FIXED_PRIORITY_EN
  // Fixed priority keeps no last-grant history.
`else
  logic              lp_q, lp_n;
`endif

  // Winner selection among the currently requesting CPUs
  always_comb begin
    win_c = 1'b0;
`ifdef ARB_FIXED_PRIORITY_EN
    win_c = ~req[0];
`else
    if (req == 2'b11) begin
      win_c = ~lp_q;
    end else begin
      win_c = req[1];
    end
`endif
  end

  // State, latched transaction and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      w_q                 <= 1'b0;
      op_q                <= 2'b00;
      cnt_q               <= '0;
`ifdef ARB_FIXED_PRIORITY_EN
`else
      lp_q                <= 1'b1;
`endif
      grant               <= 2'b00;
      cpu_search          <= 2'b00;
      BOCI                <= '0;
      cpu_datasel         <= SEL_NONE;
      cpu_dmem_permission <= 2'b00;
      done                <= 2'b00;
      busy                <= 1'b0;
    end else begin
      state               <= state_n;
      w_q                 <= w_n;
      op_q                <= op_n;
      cnt_q               <= cnt_n;
`ifdef ARB_FIXED_PRIORITY_EN
`else
      lp_q                <= lp_n;
`endif
      grant               <= grant_n;
      cpu_search          <= search_n;
      BOCI                <= boci_n;
      cpu_datasel         <= datasel_n;
      cpu_dmem_permission <= perm_n;
      done                <= done_n;
      busy                <= busy_n;
    end
  end

  // Next state and next output values; outputs reflect the state being entered
  always_comb begin
    state_n   = state;
    w_n       = w_q;
    op_n      = op_q;
    cnt_n     = cnt_q;
`ifdef ARB_FIXED_PRIORITY_EN
`else
    lp_n      = lp_q;
`endif
    grant_n   = grant;
    search_n  = 2'b00;
    boci_n    = BOCI;
    datasel_n = cpu_datasel;
    perm_n    = cpu_dmem_permission;
    done_n    = 2'b00;

    unique case (state)
      IDLE: begin
        if (req != 2'b00) begin
          w_n     = win_c;
          op_n    = win_c ? req_op[3:2] : req_op[1:0];
          boci_n  = win_c ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          grant_n = 2'b01 << win_c;
          // Writebacks never snoop the peer.
          if (op_n != OP_WB) begin
            search_n = 2'b01 << ~win_c;
          end
          state_n = GRANT;
        end
      end

      GRANT: begin
        if (op_q == OP_WB) begin
          perm_n    = 2'b01 << w_q;
          datasel_n = SEL_NONE;
          state_n   = MEM;
        end else begin
          cnt_n   = CNT_W'(SNOOP_LAT - 1);
          state_n = SNOOP;
        end
      end

      SNOOP: begin
        if (cnt_q == '0) begin
          // The peer's answer is only valid in the last snoop cycle.
          if (op_q == OP_INV) begin
            done_n  = 2'b01 << w_q;
            state_n = DONE;
          end else if (snoop_found[~w_q]) begin
            datasel_n = SEL_PEER;
            done_n    = 2'b01 << w_q;
            state_n   = DONE;
          end else begin
            perm_n    = 2'b01 << w_q;
            datasel_n = SEL_MEM;
            state_n   = MEM;
          end
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end

      MEM: begin
        if (u_rdy) begin
          done_n  = 2'b01 << w_q;
          state_n = DONE;
        end
      end

      DONE: begin
`ifdef ARB_FIXED_PRIORITY_EN
`else
        lp_n = w_q;
`endif
        grant_n   = 2'b00;
        perm_n    = 2'b00;
        datasel_n = SEL_NONE;
        state_n   = IDLE;
      end

      default: begin
        grant_n   = 2'b00;
        perm_n    = 2'b00;
        datasel_n = SEL_NONE;
        state_n   = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Randomized bench for coherence_bus_arbiter with a transaction-level model.
module tb_coherence_bus_arbiter;

  localparam int unsigned ADDR_W    = 11;
  localparam int unsigned SNOOP_LAT = 3;
  localparam int          L         = SNOOP_LAT;
  localparam int          N_ROUNDS  = 60;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req;
  logic [3:0]          req_op;
  logic [2*ADDR_W-1:0] req_addr;
  logic [1:0]          snoop_found;
  logic                u_rdy;
  logic [1:0]          grant;
  logic [1:0]          cpu_search;
  logic [ADDR_W-1:0]   BOCI;
  logic [1:0]          cpu_datasel;
  logic [1:0]          cpu_dmem_permission;
  logic [1:0]          done;
  logic                busy;

  int checks = 0;
  int errors = 0;

  // Model state: last-granted CPU and each requester's op/address
  logic              lp_m = 1'b1;
  logic [1:0]        op_a   [2];
  logic [ADDR_W-1:0] addr_a [2];

  coherence_bus_arbiter #(.ADDR_W(ADDR_W), .SNOOP_LAT(SNOOP_LAT)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req                 (req),
    .req_op              (req_op),
    .req_addr            (req_addr),
    .snoop_found         (snoop_found),
    .u_rdy               (u_rdy),
    .grant               (grant),
    .cpu_search          (cpu_search),
    .BOCI                (BOCI),
    .cpu_datasel         (cpu_datasel),
    .cpu_dmem_permission (cpu_dmem_permission),
    .done                (done),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bus();
    req_op   = {op_a[1], op_a[0]};
    req_addr = {addr_a[1], addr_a[0]};
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    case ($urandom % 4)
      0:       return 11'h005;
      1:       return 11'h7FF;
      default: return ADDR_W'($urandom);
    endcase
  endfunction

  task automatic check_reset_values(input string pfx);
    check({pfx, "_grant"},   32'(grant),               32'h0);
    check({pfx, "_search"},  32'(cpu_search),          32'h0);
    check({pfx, "_perm"},    32'(cpu_dmem_permission), 32'h0);
    check({pfx, "_done"},    32'(done),                32'h0);
    check({pfx, "_boci"},    32'(BOCI),                32'h0);
    check({pfx, "_datasel"}, 32'(cpu_datasel),         32'h3);
    check({pfx, "_busy"},    32'(busy),                32'h0);
  endtask

  // One transaction, starting in an IDLE cycle with req already driven.
  // Cycle 0 is the IDLE cycle in which the request is first sampled.
  task automatic run_txn();
    logic              w;
    logic [1:0]        opw, sf, done_v, ds_v, ds_exp, perm_exp, srch_exp;
    logic [1:0]        srch_or, perm_or, exp_g;
    logic [ADDR_W-1:0] aw, boci_v;
    bit                found, mem, gbad, bbad;
    int                m, d, dexp, c, dobs, first_perm, srch_cnt;

`ifdef ARB_FIXED_PRIORITY_EN
    w = req[0] ? 1'b0 : 1'b1;
`else
    if (req == 2'b11) w = ~lp_m;
    else              w = req[1];
`endif
    opw   = op_a[w];
    aw    = addr_a[w];
    sf    = 2'($urandom);
    found = sf[!w];
    mem   = (opw == 2'b11) || (opw != 2'b10 && !found);
    m     = (opw == 2'b11) ? 2 : 2 + L;
    d     = $urandom_range(0, 3);
    dexp  = mem ? m + d + 1 : 2 + L;
    if (opw == 2'b11 || opw == 2'b10) ds_exp = 2'b11;
    else                              ds_exp = found ? 2'b01 : 2'b00;
    perm_exp = mem ? (2'b01 << w) : 2'b00;
    srch_exp = (opw == 2'b11) ? 2'b00 : (2'b01 << !w);

    c = 0; dobs = -1; first_perm = -1; srch_cnt = 0;
    srch_or = 2'b00; perm_or = 2'b00; gbad = 1'b0; bbad = 1'b0;
    boci_v = '0; done_v = 2'b00; ds_v = 2'b00;

    while (1) begin
      exp_g = (c == 0) ? 2'b00 : (2'b01 << w);
      if (grant !== exp_g) gbad = 1'b1;
      if (busy !== (c != 0)) bbad = 1'b1;
      if (c == 1) boci_v = BOCI;
      if (cpu_search != 2'b00) begin
        srch_cnt++;
        srch_or |= cpu_search;
      end
      if (cpu_dmem_permission != 2'b00 && first_perm < 0) first_perm = c;
      perm_or |= cpu_dmem_permission;
      if (done != 2'b00) begin
        done_v = done;
        ds_v   = cpu_datasel;
        dobs   = c;
        break;
      end
      if (c >= dexp + 20) break;

      // Peer answer is only correct in the last snoop cycle.
      snoop_found = (c == 1 + L) ? sf : ~sf;
      if (mem && c == m + d)             u_rdy = 1'b1;
      else if (mem && c >= m && c < m + d) u_rdy = 1'b0;
      else                               u_rdy = ($urandom % 3 == 0);
      if (c == 1) begin
        if ($urandom % 2 == 0) begin
          op_a[w]   = 2'($urandom);
          addr_a[w] = ADDR_W'($urandom);
          drive_bus();
        end
        if ($urandom % 3 == 0) req[w] = 1'b0;
      end
      @(posedge clk); #1;
      c++;
    end

    req[w] = 1'b0;
    u_rdy  = 1'b0;
    lp_m   = w;

    check("done_val",   32'(done_v),   32'(2'b01 << w));
    check("done_cyc",   32'(dobs),     32'(dexp));
    check("datasel",    32'(ds_v),     32'(ds_exp));
    check("perm",       32'(perm_or),  32'(perm_exp));
    check("perm_cyc",   32'(first_perm), mem ? 32'(m) : 32'hFFFF_FFFF);
    check("search",     32'(srch_or),  32'(srch_exp));
    check("search_cnt", 32'(srch_cnt), (opw == 2'b11) ? 32'd0 : 32'd1);
    check("grant",      32'(gbad),     32'd0);
    check("busy",       32'(bbad),     32'd0);
    check("boci",       32'(boci_v),   32'(aw));
  endtask

  task automatic do_round(input bit force_both);
    logic [1:0] pat;
    pat = force_both ? 2'b11 : 2'($urandom_range(1, 3));
    for (int i = 0; i < 2; i++) begin
      op_a[i]   = 2'($urandom);
      addr_a[i] = rand_addr();
    end
    drive_bus();
    req = pat;
    while (req != 2'b00) begin
      run_txn();
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst         = 1'b1;
    req         = 2'b00;
    req_op      = '0;
    req_addr    = '0;
    snoop_found = 2'b00;
    u_rdy       = 1'b0;
    op_a[0] = 2'b00; op_a[1] = 2'b00;
    addr_a[0] = '0;  addr_a[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int r = 0; r < N_ROUNDS; r++) do_round(r < 2);

    // Reset while a writeback waits in MEM
    op_a[0]   = 2'b11;
    addr_a[0] = 11'h123;
    drive_bus();
    req   = 2'b01;
    u_rdy = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("pre_rst_perm", 32'(cpu_dmem_permission), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_values("midrst");
    rst  = 1'b0;
    req  = 2'b00;
    lp_m = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < N_ROUNDS / 2; r++) do_round(r == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
